axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter (AR + R only).
- Shares the single memory read port between master 0 (instruction cache miss path) and master 1 (LSU / data path).
- Round-robin grant, locked per transaction: one outstanding read burst at a time, held from AR handshake until the R beat with rlast.
- Write channels are outside this block; the top level ties or routes them.

Parameters:
- DATA_WIDTH, 32, rdata/araddr width (matches `CPU_WIDTH)
- ID_WIDTH, 4, arid/rid width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- m_arvalid, m_arready  in/out  2  per-master AR handshake, bit i = master i
- m_araddr  in  2*DATA_WIDTH  per-master address, master i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_arid  in  2*ID_WIDTH  per-master ID, same packing
- m_arlen, m_arsize, m_arburst  in  2*8, 2*3, 2*2  per-master burst attributes, same packing
- m_rvalid, m_rready  out/in  2  per-master R handshake
- m_rdata, m_rresp, m_rlast, m_rid  out  DATA_WIDTH, 2, 1, ID_WIDTH  broadcast to both masters; qualified only by m_rvalid[i]
- s_arvalid, s_arready  out/in  1  slave AR handshake
- s_araddr, s_arid, s_arlen, s_arsize, s_arburst  out  DATA_WIDTH, ID_WIDTH, 8, 3, 2  slave AR payload
- s_rvalid, s_rready  in/out  1  slave R handshake
- s_rdata, s_rresp, s_rlast, s_rid  in  DATA_WIDTH, 2, 1, ID_WIDTH  slave R payload
- o_busy  out  1  high whenever state != IDLE
- o_err  out  1  sticky burst-length mismatch flag

Behaviour:
- Reset (async, i_rst_n=0):
  - Registers: state=IDLE, grant=0, last_grant=1 (master 0 wins the first tie), beat_cnt=0, o_err=0.
  - Outputs go low immediately: m_arready, m_rvalid, s_arvalid, s_rready, o_busy.
  - A reset mid-burst abandons the transaction; no pending state survives.
- States: IDLE, ADDR, DATA. Payload muxes select on the registered grant only; there is no combinational input-to-grant path.
- IDLE:
  - All handshake outputs low.
  - If any m_arvalid is set: grant <= winner, state <= ADDR.
  - Winner when only one requests: that master.
  - Winner when both request: ~last_grant.
  - Arbitration latency is 1 cycle; earliest s_arvalid is the cycle after the request is seen.
- ADDR:
  - s_arvalid = m_arvalid[grant]; s_ar* payload = granted master's fields.
  - m_arready[grant] = s_arready; the other master's arready = 0.
  - On s_arvalid && s_arready: beat_cnt <= arlen of grant, state <= DATA.
  - If the granted master drops arvalid before the handshake (protocol violation): stay in ADDR, no switch.
- DATA:
  - m_rvalid[grant] = s_rvalid; s_rready = m_rready[grant]; the other master's rvalid = 0.
  - Each s_rvalid && s_rready beat: beat_cnt decrements; stop at 0, no wrap.
  - Final beat (handshake && s_rlast): last_grant <= grant, state <= IDLE.
  - Master back-pressure (m_rready=0) stalls the slave with no data loss.
- Fairness:
  - After master i completes, a simultaneous request gives master 1-i the grant.
  - A lone requester may be granted back-to-back, with a minimum gap of 1 IDLE cycle between transactions.
- o_err:
  - Set when s_rlast arrives on a beat with beat_cnt != 0, or when a beat with beat_cnt == 0 has s_rlast = 0.
  - Cleared only by reset. It never alters sequencing: the burst still terminates only on s_rlast.
- No ID remapping: rid is passed through unchanged; each master checks its own IDs.

Test Plan:
- Master 0 only, araddr=0x8000_0000, arlen=0 → s_araddr=0x8000_0000 one cycle after request; one R beat to master 0 with rlast=1; o_busy low the cycle after.
- Both request in the same cycle after reset → master 0 granted first; after its rlast, master 1 granted; a third simultaneous request goes back to master 0.
- Master 1 burst arlen=3, master 1 holds m_rready=0 for 2 cycles on beat 2 → s_rready=0 during the stall; 4 beats delivered in order; m_rvalid[0] stays 0 throughout.
- Slave asserts rlast on beat 2 of an arlen=3 burst → o_err=1, state returns to IDLE; o_err stays 1 across later clean transactions until reset.
- Assert i_rst_n=0 mid-DATA → s_rready, m_rvalid, o_busy drop in the same cycle; after release, a master 1 request is granted with last_grant reset to 1.
- s_arready held low 5 cycles in ADDR while master 1 requests → grant stays on master 0; m_arready[1]=0 throughout.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// axi_rd_arbiter : two-master round-robin AXI4 read (AR/R) arbiter, one burst
//                  in flight, grant locked from AR handshake to final R beat.
// Revision: 1.0
// ============================================================================
module axi_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              m_arvalid,
  output logic [1:0]              m_arready,
  input  logic [2*DATA_WIDTH-1:0] m_araddr,
  input  logic [2*ID_WIDTH-1:0]   m_arid,
  input  logic [15:0]             m_arlen,
  input  logic [5:0]              m_arsize,
  input  logic [3:0]              m_arburst,
  output logic [1:0]              m_rvalid,
  input  logic [1:0]              m_rready,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  output logic [ID_WIDTH-1:0]     m_rid,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_araddr,
  output logic [ID_WIDTH-1:0]     s_arid,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic [ID_WIDTH-1:0]     s_rid,
  output logic                    o_busy,
  output logic                    o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_grant;
  logic       r_last_grant;
  logic [7:0] r_beat_cnt;
  logic       r_err;

  logic w_winner;
  logic w_ar_hs;
  logic w_r_hs;

  // A tie goes to whichever master did not complete the previous burst.
  assign w_winner = (m_arvalid == 2'b11) ? ~r_last_grant : m_arvalid[1];
  assign w_ar_hs  = s_arvalid && s_arready;
  assign w_r_hs   = s_rvalid && s_rready;

  assign s_araddr  = r_grant ? m_araddr[2*DATA_WIDTH-1:DATA_WIDTH] : m_araddr[DATA_WIDTH-1:0];
  assign s_arid    = r_grant ? m_arid[2*ID_WIDTH-1:ID_WIDTH]       : m_arid[ID_WIDTH-1:0];
  assign s_arlen   = r_grant ? m_arlen[15:8]  : m_arlen[7:0];
  assign s_arsize  = r_grant ? m_arsize[5:3]  : m_arsize[2:0];
  assign s_arburst = r_grant ? m_arburst[3:2] : m_arburst[1:0];

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;
  assign m_rid   = s_rid;

  assign o_busy = (r_state != ST_IDLE);
  assign o_err  = r_err;

  always_comb begin
    s_arvalid = 1'b0;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    s_rready  = 1'b0;
    case (r_state)
      ST_ADDR: begin
        s_arvalid          = m_arvalid[r_grant];
        m_arready[r_grant] = s_arready;
      end
      ST_DATA: begin
        m_rvalid[r_grant] = s_rvalid;
        s_rready          = m_rready[r_grant];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|m_arvalid) begin
            r_grant <= w_winner;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_beat_cnt <= s_arlen;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            if (r_beat_cnt != 8'd0)
              r_beat_cnt <= r_beat_cnt - 8'd1;
            // Length mismatch is only flagged; the burst always ends on rlast.
            if (s_rlast != (r_beat_cnt == 8'd0))
              r_err <= 1'b1;
            if (s_rlast) begin
              r_last_grant <= r_grant;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
